// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU slice: opcodes, core control states and the
// memory arbiter's state and grant encodings.
package mips_cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Primary opcode field, instruction bits [31:26].
    typedef enum logic [5:0] {
        OP_RTYPE  = 6'h00,
        OP_REGIMM = 6'h01,
        OP_J      = 6'h02,
        OP_JAL    = 6'h03,
        OP_BEQ    = 6'h04,
        OP_BNE    = 6'h05,
        OP_ADDIU  = 6'h09,
        OP_SLTI   = 6'h0A,
        OP_ANDI   = 6'h0C,
        OP_ORI    = 6'h0D,
        OP_LUI    = 6'h0F,
        OP_LW     = 6'h23,
        OP_SW     = 6'h2B
    } opcode_t;

    // Multi-cycle core control states.
    typedef enum logic [2:0] {
        CPU_FETCH     = 3'd0,
        CPU_DECODE    = 3'd1,
        CPU_EXECUTE   = 3'd2,
        CPU_MEMORY    = 3'd3,
        CPU_WRITEBACK = 3'd4
    } cpu_state_t;

    // Memory arbiter states: waiting for a request, transfer on the bus,
    // and the single cycle that carries the completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Which requester owns the bus transfer.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Byte address to word address; the low two bits are simply discarded.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory port between the
// instruction-fetch path and the load/store path. Every output is a register.
module mips_mem_arbiter
    import mips_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_rdata,
    output logic              instr_done,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [BE_W-1:0]   data_byteenable,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,

    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,

    output logic              busy
);

    arb_state_t        state;
    arb_state_t        state_next;
    grant_t            grant;
    grant_t            grant_next;
    grant_t            last_grant;
    grant_t            last_grant_next;
    grant_t            winner;

    logic [ADDR_W-1:0] address_next;
    logic              read_next;
    logic              write_next;
    logic [DATA_W-1:0] writedata_next;
    logic [BE_W-1:0]   byteenable_next;
    logic [DATA_W-1:0] instr_rdata_next;
    logic [DATA_W-1:0] data_rdata_next;
    logic              instr_done_next;
    logic              data_done_next;
    logic              busy_next;

    // A lone requester always wins; under contention the one that did not
    // get the previous access goes next, so neither side can be starved.
    function automatic grant_t pick_grant(input logic   instr_pending,
                                          input logic   data_pending,
                                          input grant_t previous);
        grant_t result;
        if (instr_pending && data_pending) begin
            result = (previous == INSTR) ? DATA : INSTR;
        end else if (instr_pending) begin
            result = INSTR;
        end else begin
            result = DATA;
        end
        return result;
    endfunction

    // Next-state and next-output logic; every register holds unless a
    // state below says otherwise, and done pulses default low.
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        last_grant_next  = last_grant;
        address_next     = address;
        read_next        = read;
        write_next       = write;
        writedata_next   = writedata;
        byteenable_next  = byteenable;
        instr_rdata_next = instr_rdata;
        data_rdata_next  = data_rdata;
        instr_done_next  = 1'b0;
        data_done_next   = 1'b0;
        winner           = pick_grant(instr_req, data_req, last_grant);

        case (state)
            IDLE: begin
                if (instr_req || data_req) begin
                    grant_next      = winner;
                    last_grant_next = winner;
                    state_next      = BUS;
                    if (winner == INSTR) begin
                        address_next    = word_align(instr_addr);
                        read_next       = 1'b1;
                        write_next      = 1'b0;
                        byteenable_next = 4'b1111;
                    end else begin
                        address_next    = word_align(data_addr);
                        read_next       = !data_we;
                        write_next      = data_we;
                        writedata_next  = data_wdata;
                        byteenable_next = data_byteenable;
                    end
                end
            end

            BUS: begin
                if (!waitrequest) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = DONE;
                    if (grant == INSTR) begin
                        instr_rdata_next = readdata;
                        instr_done_next  = 1'b1;
                    end else begin
                        data_rdata_next  = readdata;
                        data_done_next   = 1'b1;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset abandons any transfer in flight
    // and suppresses its done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= INSTR;
            last_grant  <= DATA;
            address     <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            writedata   <= '0;
            byteenable  <= '0;
            instr_rdata <= '0;
            data_rdata  <= '0;
            instr_done  <= 1'b0;
            data_done   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_grant  <= last_grant_next;
            address     <= address_next;
            read        <= read_next;
            write       <= write_next;
            writedata   <= writedata_next;
            byteenable  <= byteenable_next;
            instr_rdata <= instr_rdata_next;
            data_rdata  <= data_rdata_next;
            instr_done  <= instr_done_next;
            data_done   <= data_done_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed testbench for mips_mem_arbiter: reset, single fetch, stalled store,
// fetch/data contention, rdata retention, reset mid-transfer, odd data accesses.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_done;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_rdata;
    logic        data_done;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    mips_mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .instr_req       (instr_req),
        .instr_addr      (instr_addr),
        .instr_rdata     (instr_rdata),
        .instr_done      (instr_done),
        .data_req        (data_req),
        .data_we         (data_we),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_byteenable (data_byteenable),
        .data_rdata      (data_rdata),
        .data_done       (data_done),
        .address         (address),
        .read            (read),
        .write           (write),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .waitrequest     (waitrequest),
        .readdata        (readdata),
        .busy            (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        compared++; if (read !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_read got %0h want 0", read); end
        compared++; if (write !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_write got %0h want 0", write); end
        compared++; if (address !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_address got %h want 0", address); end
        compared++; if (writedata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_writedata got %h want 0", writedata); end
        compared++; if (byteenable !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_byteenable got %h want 0", byteenable); end
        compared++; if (instr_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_instr_done got %0h want 0", instr_done); end
        compared++; if (data_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_data_done got %0h want 0", data_done); end
        compared++; if (instr_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr_rdata got %h want 0", instr_rdata); end
        compared++; if (data_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data_rdata got %h want 0", data_rdata); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %0h want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        instr_addr  = 32'hBFC0_0002;
        readdata    = 32'h2402_0005;
        waitrequest = 1'b0;
        instr_req   = 1'b1;
        tick();
        compared++; if (read !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_read got %0h want 1", read); end
        compared++; if (write !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_write got %0h want 0", write); end
        compared++; if (address !== 32'hBFC0_0000) begin mismatched++; $display("[TB] FAIL fetch_address got %h want bfc00000", address); end
        compared++; if (byteenable !== 4'hF) begin mismatched++; $display("[TB] FAIL fetch_byteenable got %h want f", byteenable); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_busy got %0h want 1", busy); end
        compared++; if (instr_done !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_done_early got %0h want 0", instr_done); end
        tick();
        compared++; if (read !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_read_drop got %0h want 0", read); end
        compared++; if (instr_done !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_done got %0h want 1", instr_done); end
        compared++; if (instr_rdata !== 32'h2402_0005) begin mismatched++; $display("[TB] FAIL fetch_rdata got %h want 24020005", instr_rdata); end
        compared++; if (data_done !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_data_done got %0h want 0", data_done); end
        instr_req = 1'b0;
        tick();
        compared++; if (instr_done !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_done_pulse got %0h want 0", instr_done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_idle_busy got %0h want 0", busy); end
    endtask

    task automatic test_store_wait;
        waitrequest     = 1'b1;
        data_we         = 1'b1;
        data_addr       = 32'h0000_1004;
        data_wdata      = 32'hDEAD_BEEF;
        data_byteenable = 4'b0011;
        readdata        = 32'h0BAD_F00D;
        data_req        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (write !== 1'b1) begin mismatched++; $display("[TB] FAIL store_write[%0d] got %0h want 1", i, write); end
            compared++; if (read !== 1'b0) begin mismatched++; $display("[TB] FAIL store_read[%0d] got %0h want 0", i, read); end
            compared++; if (address !== 32'h0000_1004) begin mismatched++; $display("[TB] FAIL store_address[%0d] got %h want 00001004", i, address); end
            compared++; if (writedata !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL store_writedata[%0d] got %h want deadbeef", i, writedata); end
            compared++; if (byteenable !== 4'b0011) begin mismatched++; $display("[TB] FAIL store_byteenable[%0d] got %h want 3", i, byteenable); end
            compared++; if (data_done !== 1'b0) begin mismatched++; $display("[TB] FAIL store_done_early[%0d] got %0h want 0", i, data_done); end
            if (i == 3) waitrequest = 1'b0;
        end
        tick();
        compared++; if (data_done !== 1'b1) begin mismatched++; $display("[TB] FAIL store_done got %0h want 1", data_done); end
        compared++; if (write !== 1'b0) begin mismatched++; $display("[TB] FAIL store_write_drop got %0h want 0", write); end
        compared++; if (read !== 1'b0) begin mismatched++; $display("[TB] FAIL store_read_done got %0h want 0", read); end
        compared++; if (data_rdata !== 32'h0BAD_F00D) begin mismatched++; $display("[TB] FAIL store_rdata_capture got %h want 0badf00d", data_rdata); end
        compared++; if (instr_rdata !== 32'h2402_0005) begin mismatched++; $display("[TB] FAIL store_instr_rdata_hold got %h want 24020005", instr_rdata); end
        data_req = 1'b0;
        tick();
        compared++; if (data_done !== 1'b0) begin mismatched++; $display("[TB] FAIL store_done_pulse got %0h want 0", data_done); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL store_idle_busy got %0h want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp_busy;
        logic [11:0] exp_read;
        logic [11:0] exp_idone;
        logic [11:0] exp_ddone;
        logic [31:0] exp_addr;
        exp_busy  = 12'b011_011_011_011;
        exp_read  = 12'b001_001_001_001;
        exp_idone = 12'h082;
        exp_ddone = 12'h410;
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        instr_addr  = 32'h0000_0100;
        data_addr   = 32'h0000_0200;
        data_we     = 1'b0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        instr_req   = 1'b1;
        data_req    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_addr = ((i % 6) == 0) ? 32'h0000_0100 : 32'h0000_0200;
            compared++; if (busy !== exp_busy[i]) begin mismatched++; $display("[TB] FAIL b2b_busy[%0d] got %0h want %0h", i, busy, exp_busy[i]); end
            compared++; if (read !== exp_read[i]) begin mismatched++; $display("[TB] FAIL b2b_read[%0d] got %0h want %0h", i, read, exp_read[i]); end
            compared++; if (write !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_write[%0d] got %0h want 0", i, write); end
            compared++; if (instr_done !== exp_idone[i]) begin mismatched++; $display("[TB] FAIL b2b_instr_done[%0d] got %0h want %0h", i, instr_done, exp_idone[i]); end
            compared++; if (data_done !== exp_ddone[i]) begin mismatched++; $display("[TB] FAIL b2b_data_done[%0d] got %0h want %0h", i, data_done, exp_ddone[i]); end
            if (exp_read[i]) begin
                compared++; if (address !== exp_addr) begin mismatched++; $display("[TB] FAIL b2b_address[%0d] got %h want %h", i, address, exp_addr); end
            end
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_settle_busy got %0h want 0", busy); end
    endtask

    task automatic test_rdata_hold;
        data_we   = 1'b0;
        data_addr = 32'h0000_2008;
        readdata  = 32'h1234_5678;
        data_req  = 1'b1;
        tick();
        compared++; if (read !== 1'b1) begin mismatched++; $display("[TB] FAIL load_read got %0h want 1", read); end
        compared++; if (address !== 32'h0000_2008) begin mismatched++; $display("[TB] FAIL load_address got %h want 00002008", address); end
        tick();
        compared++; if (data_done !== 1'b1) begin mismatched++; $display("[TB] FAIL load_done got %0h want 1", data_done); end
        compared++; if (data_rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL load_rdata got %h want 12345678", data_rdata); end
        data_req = 1'b0;
        tick();
        instr_addr = 32'h0040_0004;
        readdata   = 32'hCAFE_F00D;
        instr_req  = 1'b1;
        tick();
        tick();
        compared++; if (instr_done !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_fetch_done got %0h want 1", instr_done); end
        compared++; if (instr_rdata !== 32'hCAFE_F00D) begin mismatched++; $display("[TB] FAIL hold_instr_rdata got %h want cafef00d", instr_rdata); end
        compared++; if (data_rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL hold_data_rdata got %h want 12345678", data_rdata); end
        instr_req = 1'b0;
        tick();
        compared++; if (data_rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL hold_data_rdata_after got %h want 12345678", data_rdata); end
    endtask

    task automatic test_reset_in_bus;
        waitrequest = 1'b1;
        data_we     = 1'b0;
        data_addr   = 32'h0000_3000;
        readdata    = 32'h55AA_55AA;
        data_req    = 1'b1;
        tick();
        tick();
        compared++; if (read !== 1'b1) begin mismatched++; $display("[TB] FAIL rstbus_stalled_read got %0h want 1", read); end
        rst = 1'b1;
        tick();
        compared++; if (read !== 1'b0) begin mismatched++; $display("[TB] FAIL rstbus_read got %0h want 0", read); end
        compared++; if (write !== 1'b0) begin mismatched++; $display("[TB] FAIL rstbus_write got %0h want 0", write); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstbus_busy got %0h want 0", busy); end
        compared++; if (data_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstbus_done got %0h want 0", data_done); end
        compared++; if (address !== 32'h0) begin mismatched++; $display("[TB] FAIL rstbus_address got %h want 0", address); end
        compared++; if (data_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rstbus_rdata got %h want 0", data_rdata); end
        rst         = 1'b0;
        waitrequest = 1'b0;
        tick();
        compared++; if (read !== 1'b1) begin mismatched++; $display("[TB] FAIL rstbus_retry_read got %0h want 1", read); end
        compared++; if (address !== 32'h0000_3000) begin mismatched++; $display("[TB] FAIL rstbus_retry_address got %h want 00003000", address); end
        compared++; if (data_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstbus_retry_early got %0h want 0", data_done); end
        tick();
        compared++; if (data_done !== 1'b1) begin mismatched++; $display("[TB] FAIL rstbus_retry_done got %0h want 1", data_done); end
        compared++; if (data_rdata !== 32'h55AA_55AA) begin mismatched++; $display("[TB] FAIL rstbus_retry_rdata got %h want 55aa55aa", data_rdata); end
        data_req = 1'b0;
        tick();
    endtask

    task automatic test_zero_be_misaligned;
        waitrequest     = 1'b0;
        data_we         = 1'b1;
        data_addr       = 32'h0000_0007;
        data_wdata      = 32'hA5A5_A5A5;
        data_byteenable = 4'b0000;
        data_req        = 1'b1;
        tick();
        compared++; if (write !== 1'b1) begin mismatched++; $display("[TB] FAIL zbe_write got %0h want 1", write); end
        compared++; if (read !== 1'b0) begin mismatched++; $display("[TB] FAIL zbe_read got %0h want 0", read); end
        compared++; if (address !== 32'h0000_0004) begin mismatched++; $display("[TB] FAIL zbe_address got %h want 00000004", address); end
        compared++; if (byteenable !== 4'b0000) begin mismatched++; $display("[TB] FAIL zbe_byteenable got %h want 0", byteenable); end
        compared++; if (writedata !== 32'hA5A5_A5A5) begin mismatched++; $display("[TB] FAIL zbe_writedata got %h want a5a5a5a5", writedata); end
        tick();
        compared++; if (data_done !== 1'b1) begin mismatched++; $display("[TB] FAIL zbe_done got %0h want 1", data_done); end
        data_req = 1'b0;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL zbe_idle_busy got %0h want 0", busy); end
    endtask

    // Drive every input to a known value, then run the scenarios in order.
    initial begin
        rst             = 1'b1;
        instr_req       = 1'b0;
        instr_addr      = 32'h0;
        data_req        = 1'b0;
        data_we         = 1'b0;
        data_addr       = 32'h0;
        data_wdata      = 32'h0;
        data_byteenable = 4'h0;
        waitrequest     = 1'b0;
        readdata        = 32'h0;

        test_reset();
        test_fetch();
        test_store_wait();
        test_back_to_back();
        test_rdata_hold();
        test_reset_in_bus();
        test_zero_be_misaligned();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Two-requester arbiter that shares one Avalon-style memory port between the CPU instruction-fetch path and the load/store data path. It sits between the CPU core and the single unified memory bus. It serialises accesses, aligns addresses to words, and returns read data with a one-cycle completion pulse to whichever requester was granted. Fairness is round-robin, so a stream of loads/stores can never starve fetch, and fetch can never starve data.

## Interface
Parameters: none. Width is fixed at 32-bit address and 32-bit data.

- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- instr_req  in  1  fetch request, level; held until instr_done
- instr_addr  in  32  fetch byte address
- instr_rdata  out  32  fetched word; valid while instr_done=1
- instr_done  out  1  one-cycle completion pulse for fetch
- data_req  in  1  data request, level; held until data_done
- data_we  in  1  1=write, 0=read; stable while data_req=1
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_byteenable  in  4  byte lanes for the data access
- data_rdata  out  32  load word; valid while data_done=1
- data_done  out  1  one-cycle completion pulse for data
- address  out  32  bus address, word-aligned
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  32  bus write data
- byteenable  out  4  bus byte lanes
- waitrequest  in  1  bus stall; transfer completes on an edge where strobe=1 and waitrequest=0
- readdata  in  32  bus read data; valid on the completing edge
- busy  out  1  1 in any state other than IDLE

## Operation
- State machine: IDLE, BUS, DONE.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both requests are pending, grant the requester that is not last_grant.
  - On a grant: latch the grant, drive the bus registers for the granted requester, update last_grant, and go to BUS.
- **Bus fields on a fetch grant:** address={instr_addr[31:2],2'b00}, read=1, write=0, byteenable=4'b1111.
- **Bus fields on a data grant:** address={data_addr[31:2],2'b00}, read=!data_we, write=data_we, writedata=data_wdata, byteenable=data_byteenable.
- **BUS:**
  - Hold every bus output stable while waitrequest=1.
  - On the edge where waitrequest=0:
    - capture readdata into the granted requester's rdata register (this happens for writes too);
    - drop read and write;
    - go to DONE.
- **DONE:**
  - Assert the granted requester's done for exactly this cycle.
  - Requests are not sampled in DONE.
  - Always go to IDLE next.
- Requester contract: drop req on the edge that ends the done cycle, or keep it high to request a new access.
- instr_rdata and data_rdata hold their last captured value until the next capture for that requester.
- The bus is never driven with read=1 and write=1 together.
- A data request with data_byteenable=0 is still issued to the bus unchanged.
- Misaligned addresses: bits [1:0] are dropped; no exception is raised.
- Reset values: read=0, write=0, address=0, writedata=0, byteenable=0, instr_done=0, data_done=0, instr_rdata=0, data_rdata=0, busy=0, state=IDLE, last_grant=DATA.
- Because last_grant resets to DATA, fetch wins the first contention after reset.
- Reset asserted in BUS or DONE: all outputs take their reset values on that edge, the transaction is abandoned, and no done pulse is issued.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Request seen high in IDLE in cycle N: strobe is high from cycle N+1.
- Zero-wait bus: completing edge at the end of N+1, done high in N+2, IDLE in N+3.
- Minimum turnaround is 3 cycles per access; each cycle waitrequest stays high adds one cycle.
- Back-to-back contention: grants alternate fetch/data. Under continuous contention each requester gets one access per 6 cycles.
- A request raised during BUS or DONE is first considered in the following IDLE cycle.

## Structure
- The state enum (IDLE, BUS, DONE) and grant enum (INSTR, DATA) go in the shared package mips_cpu_pkg, next to the CPU opcode and state typedefs.
- Single module, no sub-module. Round-robin selection is an inline function of (instr_req, data_req, last_grant).

## Test plan
- Fetch only, waitrequest=0, instr_addr=0xBFC00002, readdata=0x24020005:
  - address=0xBFC00000 and read=1 for 1 cycle;
  - instr_done pulses 2 cycles after req, with instr_rdata=0x24020005.
- Data store with 3 wait cycles: data_we=1, data_addr=0x1004, data_wdata=0xDEADBEEF, byteenable=4'b0011.
  - write, address, writedata and byteenable are held 4 cycles;
  - data_done pulses once; read stays 0 throughout.
- Both requesters raise req in the same cycle right after reset, and both re-request continuously:
  - grant order is INSTR, DATA, INSTR, DATA;
  - no strobe overlap; busy drops for exactly one IDLE cycle between accesses.
- Load with readdata=0x12345678 followed by a fetch with readdata=0xCAFEF00D:
  - data_rdata keeps 0x12345678 after the fetch completes;
  - instr_rdata=0xCAFEF00D.
- rst asserted in BUS while waitrequest=1:
  - next cycle read=0, write=0, busy=0, no done pulse;
  - the next request is served normally.
